// File: rtl/imem_loader_pkg.sv
// Shared widths and loader state encoding.
// Imported by the loader, its RAM and the PC/decoder.
package imem_loader_pkg;

  localparam int IMEM_AW = 6;
  localparam int IMEM_DW = 16;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host program-load stream.
// The host is the master; the loader is the slave.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int DW = IMEM_DW
);

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/imem_loader_ram.sv
// Instruction RAM: one write port, one registered read port.
// A same-address read and write returns the old word.
module imem_loader_ram
  import imem_loader_pkg::*;
#(
  parameter int AW = IMEM_AW,
  parameter int DW = IMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Contents survive reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with host program loader.
// Holds the core in reset while a program streams in.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AW = IMEM_AW,
  parameter int DW = IMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  output logic          core_rst_n,
  imem_loader_if.slave  ld,
  input  logic          ld_reload,
  output logic [AW:0]   ld_count,
  output logic          ld_ovf
);

  localparam logic [AW:0]   FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] WMAX = '1;

  state_t        state;
  state_t        state_nx;
  logic          accept;
  logic          reload_go;
  logic [AW-1:0] wptr;

  always_comb begin
    state_nx    = state;
    ld.ld_ready = 1'b0;
    accept      = 1'b0;
    reload_go   = 1'b0;
    unique case (state)
      S_LOAD: begin
        ld.ld_ready = 1'b1;
        accept      = ld.ld_valid;
        if (accept && ld.ld_last)
          state_nx = S_RUN;
      end
      S_RUN: begin
        reload_go = ld_reload;
        if (ld_reload)
          state_nx = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      wptr        <= '0;
      ld_count    <= '0;
      ld_ovf      <= 1'b0;
      core_rst_n  <= 1'b0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nx;
      core_rst_n  <= (state == S_RUN) && !ld_reload;
      // Valid lags core_rst_n so the PC's first fetch is mem[0].
      instr_valid <= (state == S_RUN) && core_rst_n
                     && !ld_reload;
      instr_pc    <= fetch_addr;
      if (reload_go) begin
        wptr     <= '0;
        ld_count <= '0;
        ld_ovf   <= 1'b0;
      end else if (accept) begin
        wptr <= wptr + 1'b1;
        if (ld_count != FULL)
          ld_count <= ld_count + 1'b1;
        if (wptr == WMAX && !ld.ld_last)
          ld_ovf <= 1'b1;
      end
    end
  end

  imem_loader_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (wptr),
    .wdata (ld.ld_data),
    .raddr (fetch_addr),
    .rdata (instr_out)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Fetch results are checked against a memory model via a queue.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = IMEM_AW;
  localparam int DW = IMEM_DW;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          core_rst_n;
  logic          ld_reload;
  logic [AW:0]   ld_count;
  logic          ld_ovf;

  imem_loader_if #(.DW(DW)) ld_if ();

  imem_loader #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_addr  (fetch_addr),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .core_rst_n  (core_rst_n),
    .ld          (ld_if),
    .ld_reload   (ld_reload),
    .ld_count    (ld_count),
    .ld_ovf      (ld_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0]    mdl [DEPTH];
  int               wp_m;
  int               cnt_m;
  logic             ovf_m;
  logic [AW+DW-1:0] sb [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d,
                           input logic last);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = d;
    ld_if.ld_last  = last;
    chk("ld_ready_load", 32'(ld_if.ld_ready), 1);
    tick();
    mdl[wp_m] = d;
    if (wp_m == DEPTH-1 && !last) ovf_m = 1'b1;
    wp_m = (wp_m + 1) % DEPTH;
    if (cnt_m < DEPTH) cnt_m++;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 0);
    chk({tag, "_instr_out"}, 32'(instr_out), 0);
    chk({tag, "_instr_pc"}, 32'(instr_pc), 0);
    chk({tag, "_ld_count"}, 32'(ld_count), 0);
    chk({tag, "_ld_ovf"}, 32'(ld_ovf), 0);
    chk({tag, "_ld_ready"}, 32'(ld_if.ld_ready), 1);
  endtask

  // Called right after the last accepted word.
  task automatic release_core(input string tag);
    chk({tag, "_run_ready"}, 32'(ld_if.ld_ready), 0);
    chk({tag, "_core_hold"}, 32'(core_rst_n), 0);
    fetch_addr = '0;
    tick();
    chk({tag, "_core_rise"}, 32'(core_rst_n), 1);
    chk({tag, "_valid_lag"}, 32'(instr_valid), 0);
    tick();
    chk({tag, "_valid_rise"}, 32'(instr_valid), 1);
    chk({tag, "_first_pc"}, 32'(instr_pc), 0);
    chk({tag, "_first_word"}, 32'(instr_out), 32'(mdl[0]));
  endtask

  task automatic fetch(input int a);
    logic [AW+DW-1:0] e;
    fetch_addr = AW'(a);
    sb.push_back({AW'(a), mdl[a]});
    tick();
    e = sb.pop_front();
    chk("fetch_instr_out", 32'(instr_out), 32'(e[DW-1:0]));
    chk("fetch_instr_pc", 32'(instr_pc),
        32'(e[AW+DW-1:DW]));
    chk("fetch_valid", 32'(instr_valid), 1);
  endtask

  task automatic do_reload();
    ld_reload = 1'b1;
    tick();
    ld_reload = 1'b0;
    chk("reload_ready", 32'(ld_if.ld_ready), 1);
    chk("reload_core", 32'(core_rst_n), 0);
    chk("reload_valid", 32'(instr_valid), 0);
    chk("reload_count", 32'(ld_count), 0);
    chk("reload_ovf", 32'(ld_ovf), 0);
    wp_m  = 0;
    cnt_m = 0;
    ovf_m = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_addr     = '0;
    ld_reload      = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.ld_last  = 1'b0;
    wp_m  = 0;
    cnt_m = 0;
    ovf_m = 1'b0;
    tick();
    tick();
    chk_reset_vals("por");
    rst_n = 1'b1;

    // Basic four-word load then release
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    load_word(16'h3333, 1'b0);
    load_word(16'h4444, 1'b1);
    chk("t1_count", 32'(ld_count), 32'(cnt_m));
    chk("t1_count4", 32'(ld_count), 4);
    release_core("t1");
    chk("t1_word0", 32'(instr_out), 32'h1111);

    // Host stalls mid-load
    do_reload();
    load_word(16'hBEEF, 1'b0);
    ld_if.ld_data = 16'hDEAD;
    tick();
    chk("t2_stall1_count", 32'(ld_count), 1);
    tick();
    chk("t2_stall2_count", 32'(ld_count), 1);
    load_word(16'hCAFE, 1'b1);
    chk("t2_count", 32'(ld_count), 2);
    release_core("t2");
    fetch(0);
    fetch(1);
    fetch(2);

    // 65-word overflow load
    do_reload();
    for (int i = 0; i < DEPTH + 1; i++)
      load_word(16'hA000 + 16'(i), i == DEPTH);
    chk("t3_ovf", 32'(ld_ovf), 32'(ovf_m));
    chk("t3_ovf1", 32'(ld_ovf), 1);
    chk("t3_count_sat", 32'(ld_count), 64);
    chk("t3_mdl0", 32'(mdl[0]), 32'hA040);
    release_core("t3");

    // Fetches with a jump
    fetch(5);
    fetch(6);
    fetch(20);
    fetch(21);
    fetch(63);

    // Reset mid-load
    do_reload();
    load_word(16'h5555, 1'b0);
    load_word(16'h6666, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_vals("t6");
    wp_m  = 0;
    cnt_m = 0;
    ovf_m = 1'b0;
    load_word(16'h7777, 1'b0);
    load_word(16'h8888, 1'b0);
    load_word(16'h9999, 1'b0);
    load_word(16'hAAAA, 1'b1);
    chk("t6_count", 32'(ld_count), 4);
    release_core("t6");
    for (int i = 0; i < 4; i++)
      fetch(i);
    fetch(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
